fetch_unit: RTL and testbench



---
 rtl/fetch_unit.sv | 114 +++++++++++
 tb/tb_fetch_unit.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// In-order fetch stage: holds PC and commit-order tag, issues one outstanding imem read,
// pushes returned words into the instruction queue. Optional counters under FETCH_PERF_EN.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h1eceb000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  output logic [3:0]  imem_rmask,
  input  logic [31:0] imem_rdata,
  input  logic        imem_resp,
  input  logic        instr_full,
  output logic        instr_push,
  output logic [31:0] instr_in,
  output logic [63:0] order_in,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic [63:0] redirect_order
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_full_stall,
  output logic [31:0] perf_discard
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DISCARD
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic [63:0] order;
  logic        issue;
  logic        push;
  logic [31:0] redir_pc_al;

  assign redir_pc_al = redirect_pc & 32'hFFFF_FFFC;

  // rst gates the strobes so nothing is requested or pushed while reset is held
  always_comb begin
    issue      = !rst && (state == IDLE) && !redirect_valid && !instr_full;
    push       = !rst && (state == WAIT) && imem_resp && !redirect_valid;
    imem_rmask = issue ? 4'hF : 4'h0;
    imem_addr  = pc & 32'hFFFF_FFFC;
    instr_push = push;
    instr_in   = push ? imem_rdata : '0;
    order_in   = push ? order : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      pc    <= RESET_PC;
      order <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (redirect_valid) begin
            pc    <= redir_pc_al;
            order <= redirect_order;
          end else if (!instr_full) begin
            state <= WAIT;
          end
        end
        WAIT: begin
          if (redirect_valid) begin
            pc    <= redir_pc_al;
            order <= redirect_order;
            state <= imem_resp ? IDLE : DISCARD;
          end else if (imem_resp) begin
            pc    <= pc + PC_STEP;
            order <= order + 64'd1;
            state <= IDLE;
          end
        end
        DISCARD: begin
          if (redirect_valid) begin
            pc    <= redir_pc_al;
            order <= redirect_order;
          end
          if (imem_resp) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FETCH_PERF_EN
  logic stall_cyc;
  logic drop;

  always_comb begin
    stall_cyc = (state == IDLE) && instr_full && !redirect_valid;
    drop      = imem_resp && ((state == DISCARD) || ((state == WAIT) && redirect_valid));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetched    <= '0;
      perf_full_stall <= '0;
      perf_discard    <= '0;
    end else begin
      if (push && perf_fetched != '1)         perf_fetched    <= perf_fetched + 32'd1;
      if (stall_cyc && perf_full_stall != '1) perf_full_stall <= perf_full_stall + 32'd1;
      if (drop && perf_discard != '1)         perf_discard    <= perf_discard + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: per-cycle transaction model (PC, order tag,
// outstanding/stale request) plus a variable-latency memory responder.
module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h1eceb000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] imem_addr;
  logic [3:0]  imem_rmask;
  logic [31:0] imem_rdata;
  logic        imem_resp;
  logic        instr_full;
  logic        instr_push;
  logic [31:0] instr_in;
  logic [63:0] order_in;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [63:0] redirect_order;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched, perf_full_stall, perf_discard;
`endif

  fetch_unit #(.RESET_PC(RST_PC), .PC_STEP(32'd4)) dut (
    .clk(clk), .rst(rst),
    .imem_addr(imem_addr), .imem_rmask(imem_rmask),
    .imem_rdata(imem_rdata), .imem_resp(imem_resp),
    .instr_full(instr_full), .instr_push(instr_push),
    .instr_in(instr_in), .order_in(order_in),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .redirect_order(redirect_order)
`ifdef FETCH_PERF_EN
    , .perf_fetched(perf_fetched), .perf_full_stall(perf_full_stall),
    .perf_discard(perf_discard)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int unsigned cyc = 0;

  // memory responder
  logic        mem_pending = 1'b0;
  int unsigned mem_due = 0;

  // reference model
  logic [31:0] m_pc = RST_PC;
  logic [63:0] m_order = '0;
  logic        m_out = 1'b0;
  logic        m_stale = 1'b0;
  logic [31:0] m_fetched = '0, m_stall = '0, m_discard = '0;

  logic [132:0] obs_vec, exp_vec;

  task automatic run_cycle(input logic r, input logic full, input logic redir,
                           input logic [31:0] rpc, input logic [63:0] rord,
                           input int unsigned lat);
    logic resp, e_push, e_issue;
    logic [31:0] word;
    @(posedge clk);
    #1;
    cyc++;
    resp = !r && mem_pending && (cyc == mem_due);
    word = $urandom;
    rst = r; instr_full = full; redirect_valid = redir;
    redirect_pc = rpc; redirect_order = rord;
    imem_resp = resp; imem_rdata = word;
    #1;
    e_push  = !r && m_out && !m_stale && resp && !redir;
    e_issue = !r && !m_out && !redir && !full;
    exp_vec = {e_issue ? 4'hF : 4'h0, m_pc, e_push,
               e_push ? word : 32'h0, e_push ? m_order : 64'h0};
    obs_vec = {imem_rmask, imem_addr, instr_push,
               e_push ? instr_in : 32'h0, e_push ? order_in : 64'h0};
    if (r) begin
      m_pc = RST_PC; m_order = '0; m_out = 1'b0; m_stale = 1'b0;
      mem_pending = 1'b0;
      m_fetched = '0; m_stall = '0; m_discard = '0;
    end else begin
      if (e_push && m_fetched != 32'hFFFF_FFFF) m_fetched++;
      if (!m_out && full && !redir && m_stall != 32'hFFFF_FFFF) m_stall++;
      if (resp && m_out && (m_stale || redir) && m_discard != 32'hFFFF_FFFF) m_discard++;
      if (resp) begin
        m_out = 1'b0; m_stale = 1'b0; mem_pending = 1'b0;
      end
      if (redir) begin
        m_pc = {rpc[31:2], 2'b00};
        m_order = rord;
        if (m_out) m_stale = 1'b1;
      end else if (e_push) begin
        m_pc = m_pc + 32'd4;
        m_order = m_order + 64'd1;
      end
      if (e_issue) m_out = 1'b1;
      if (imem_rmask == 4'hF) begin
        mem_pending = 1'b1;
        mem_due = cyc + lat;
      end
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      run_cycle(1'b1, 1'b0, 1'b0, 32'h0, 64'h0, 1);
      total++;
      if (obs_vec !== exp_vec) begin
        bad++; $display("FAIL reset_model cyc=%0d got=%h want=%h", cyc, obs_vec, exp_vec);
      end
      total++;
      if ({imem_rmask, instr_push, imem_addr, instr_in, order_in} !== {4'h0, 1'b0, RST_PC, 32'h0, 64'h0}) begin
        bad++; $display("FAIL reset_values cyc=%0d got rmask=%h push=%b addr=%h in=%h ord=%h want 0/0/%h/0/0",
                        cyc, imem_rmask, instr_push, imem_addr, instr_in, order_in, RST_PC);
      end
    end
  endtask

  task automatic test_basic();
    logic [31:0] want_addr [4];
    logic [3:0]  want_mask [4];
    logic        want_push [4];
    logic [63:0] want_ord  [4];
    want_addr = '{32'h1eceb000, 32'h1eceb000, 32'h1eceb004, 32'h1eceb004};
    want_mask = '{4'hF, 4'h0, 4'hF, 4'h0};
    want_push = '{1'b0, 1'b1, 1'b0, 1'b1};
    want_ord  = '{64'd0, 64'd0, 64'd0, 64'd1};
    for (int i = 0; i < 4; i++) begin
      run_cycle(1'b0, 1'b0, 1'b0, 32'h0, 64'h0, 1);
      total++;
      if (obs_vec !== exp_vec) begin
        bad++; $display("FAIL basic_model cyc=%0d got=%h want=%h", cyc, obs_vec, exp_vec);
      end
      total++;
      if ({imem_rmask, imem_addr, instr_push} !== {want_mask[i], want_addr[i], want_push[i]} ||
          (want_push[i] && order_in !== want_ord[i])) begin
        bad++; $display("FAIL basic_fixed step=%0d got rmask=%h addr=%h push=%b ord=%h want %h/%h/%b/%h",
                        i, imem_rmask, imem_addr, instr_push, order_in,
                        want_mask[i], want_addr[i], want_push[i], want_ord[i]);
      end
    end
  endtask

  task automatic test_full_stall();
    logic [31:0] pc0;
    pc0 = m_pc;
    for (int i = 0; i < 5; i++) begin
      run_cycle(1'b0, 1'b1, 1'b0, 32'h0, 64'h0, 1);
      total++;
      if (imem_rmask !== 4'h0 || imem_addr !== pc0 || obs_vec !== exp_vec) begin
        bad++; $display("FAIL full_stall cyc=%0d got rmask=%h addr=%h want 0/%h", cyc, imem_rmask, imem_addr, pc0);
      end
    end
    run_cycle(1'b0, 1'b0, 1'b0, 32'h0, 64'h0, 1);
    total++;
    if (imem_rmask !== 4'hF || imem_addr !== pc0) begin
      bad++; $display("FAIL full_release got rmask=%h addr=%h want F/%h", imem_rmask, imem_addr, pc0);
    end
    run_cycle(1'b0, 1'b0, 1'b0, 32'h0, 64'h0, 1);
    total++;
    if (obs_vec !== exp_vec) begin
      bad++; $display("FAIL full_resp got=%h want=%h", obs_vec, exp_vec);
    end
  endtask

  task automatic test_redirect_wait();
    run_cycle(1'b0, 1'b0, 1'b0, 32'h0, 64'h0, 3);
    run_cycle(1'b0, 1'b0, 1'b1, 32'h1eceb101, 64'h20, 3);
    for (int i = 0; i < 2; i++) begin
      run_cycle(1'b0, 1'b0, 1'b0, 32'h0, 64'h0, 1);
      total++;
      if (instr_push !== 1'b0 || imem_rmask !== 4'h0 || obs_vec !== exp_vec) begin
        bad++; $display("FAIL redir_drop cyc=%0d got push=%b rmask=%h want 0/0", cyc, instr_push, imem_rmask);
      end
    end
    run_cycle(1'b0, 1'b0, 1'b0, 32'h0, 64'h0, 1);
    total++;
    if (imem_rmask !== 4'hF || imem_addr !== 32'h1eceb100) begin
      bad++; $display("FAIL redir_addr got rmask=%h addr=%h want F/1eceb100", imem_rmask, imem_addr);
    end
    run_cycle(1'b0, 1'b0, 1'b0, 32'h0, 64'h0, 1);
    total++;
    if (instr_push !== 1'b1 || order_in !== 64'h20 || obs_vec !== exp_vec) begin
      bad++; $display("FAIL redir_order got push=%b ord=%h want 1/20", instr_push, order_in);
    end
  endtask

  task automatic test_redirect_coincident();
    run_cycle(1'b0, 1'b0, 1'b0, 32'h0, 64'h0, 1);
    run_cycle(1'b0, 1'b0, 1'b1, 32'h0000_1238, 64'd5, 1);
    total++;
    if (instr_push !== 1'b0 || obs_vec !== exp_vec) begin
      bad++; $display("FAIL coinc_push got push=%b want 0", instr_push);
    end
    run_cycle(1'b0, 1'b0, 1'b0, 32'h0, 64'h0, 1);
    total++;
    if (imem_rmask !== 4'hF || imem_addr !== 32'h0000_1238) begin
      bad++; $display("FAIL coinc_addr got rmask=%h addr=%h want F/00001238", imem_rmask, imem_addr);
    end
    run_cycle(1'b0, 1'b0, 1'b0, 32'h0, 64'h0, 1);
    total++;
    if (instr_push !== 1'b1 || order_in !== 64'd5) begin
      bad++; $display("FAIL coinc_order got push=%b ord=%h want 1/5", instr_push, order_in);
    end
  endtask

  task automatic test_wrap();
    run_cycle(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1);
    for (int i = 0; i < 4; i++) begin
      run_cycle(1'b0, 1'b0, 1'b0, 32'h0, 64'h0, 1);
      total++;
      if (obs_vec !== exp_vec || imem_addr[1:0] !== 2'b00) begin
        bad++; $display("FAIL wrap cyc=%0d got=%h want=%h", cyc, obs_vec, exp_vec);
      end
    end
    total++;
    if (order_in !== 64'd0 || imem_addr !== 32'h0) begin
      bad++; $display("FAIL wrap_final got ord=%h addr=%h want 0/0", order_in, imem_addr);
    end
  endtask

  task automatic test_reset_mid();
    run_cycle(1'b0, 1'b0, 1'b1, 32'h0000_4000, 64'd77, 1);
    run_cycle(1'b0, 1'b0, 1'b0, 32'h0, 64'h0, 3);
    run_cycle(1'b1, 1'b0, 1'b0, 32'h0, 64'h0, 3);
    total++;
    if (instr_push !== 1'b0 || imem_rmask !== 4'h0) begin
      bad++; $display("FAIL rstmid_hold got push=%b rmask=%h want 0/0", instr_push, imem_rmask);
    end
    run_cycle(1'b0, 1'b0, 1'b0, 32'h0, 64'h0, 1);
    total++;
    if (imem_rmask !== 4'hF || imem_addr !== RST_PC || obs_vec !== exp_vec) begin
      bad++; $display("FAIL rstmid_restart got rmask=%h addr=%h want F/%h", imem_rmask, imem_addr, RST_PC);
    end
    run_cycle(1'b0, 1'b0, 1'b0, 32'h0, 64'h0, 1);
    total++;
    if (instr_push !== 1'b1 || order_in !== 64'd0) begin
      bad++; $display("FAIL rstmid_push got push=%b ord=%h want 1/0", instr_push, order_in);
    end
  endtask

  task automatic test_random();
    logic r, f, d;
    logic [63:0] ord;
    for (int i = 0; i < 600; i++) begin
      r = ($urandom_range(99) == 0);
      f = ($urandom_range(3) == 0);
      d = ($urandom_range(9) == 0);
      ord = {$urandom, $urandom};
      if ($urandom_range(3) == 0) ord = 64'hFFFF_FFFF_FFFF_FFFE;
      run_cycle(r, f, d, $urandom, ord, $urandom_range(4, 1));
      total++;
      if (obs_vec !== exp_vec) begin
        bad++; $display("FAIL random cyc=%0d got=%h want=%h", cyc, obs_vec, exp_vec);
      end
    end
  endtask

`ifdef FETCH_PERF_EN
  task automatic test_perf();
    run_cycle(1'b1, 1'b0, 1'b0, 32'h0, 64'h0, 1);
    run_cycle(1'b1, 1'b0, 1'b0, 32'h0, 64'h0, 1);
    for (int i = 0; i < 3; i++) run_cycle(1'b0, 1'b1, 1'b0, 32'h0, 64'h0, 1);
    run_cycle(1'b0, 1'b0, 1'b0, 32'h0, 64'h0, 2);
    run_cycle(1'b0, 1'b0, 1'b1, 32'h0000_8000, 64'd0, 2);
    run_cycle(1'b0, 1'b0, 1'b0, 32'h0, 64'h0, 1);
    for (int i = 0; i < 20; i++) run_cycle(1'b0, 1'b0, 1'b0, 32'h0, 64'h0, 1);
    run_cycle(1'b0, 1'b0, 1'b1, 32'h0000_8000, 64'd0, 1);
    total++;
    if ({perf_fetched, perf_full_stall, perf_discard} !== {32'd10, 32'd3, 32'd1}) begin
      bad++; $display("FAIL perf got f=%0d s=%0d d=%0d want 10/3/1", perf_fetched, perf_full_stall, perf_discard);
    end
    total++;
    if ({perf_fetched, perf_full_stall, perf_discard} !== {m_fetched, m_stall, m_discard}) begin
      bad++; $display("FAIL perf_model got f=%0d s=%0d d=%0d want %0d/%0d/%0d",
                      perf_fetched, perf_full_stall, perf_discard, m_fetched, m_stall, m_discard);
    end
  endtask
`endif

  initial begin
    rst = 1'b1; instr_full = 1'b0; redirect_valid = 1'b0;
    redirect_pc = '0; redirect_order = '0; imem_resp = 1'b0; imem_rdata = '0;
    test_reset();
    test_basic();
    test_full_stall();
    test_redirect_wait();
    test_redirect_coincident();
    test_wrap();
    test_reset_mid();
    test_random();
`ifdef FETCH_PERF_EN
    test_perf();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
